// File: rtl/cache_fill_fsm_if.sv
// Signal bundle between the block refill FSM and the miss logic, memory and data/tag arrays.
// Optional macro FILL_PERF_CNT_EN adds the fill_count / stall_cycles performance counters.
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic [1:0]        victim_way;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              mem_read_req;
  logic [ADDR_W-1:0] memory_address;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        data_write;
  logic [WORDS-1:0]  word_enable;
  logic [1:0]        tag_write;
  logic              fill_done;
`ifdef FILL_PERF_CNT_EN
  logic [15:0]       fill_count;
  logic [15:0]       stall_cycles;

  // master: the refill FSM; slave: miss logic, memory and arrays
  modport master (
    input  miss_detected, miss_address, victim_way, memory_data, memory_data_valid,
    output fsm_busy, mem_read_req, memory_address, data_out, data_write,
           word_enable, tag_write, fill_done, fill_count, stall_cycles
  );
  modport slave (
    output miss_detected, miss_address, victim_way, memory_data, memory_data_valid,
    input  fsm_busy, mem_read_req, memory_address, data_out, data_write,
           word_enable, tag_write, fill_done, fill_count, stall_cycles
  );
`else
  modport master (
    input  miss_detected, miss_address, victim_way, memory_data, memory_data_valid,
    output fsm_busy, mem_read_req, memory_address, data_out, data_write,
           word_enable, tag_write, fill_done
  );
  modport slave (
    output miss_detected, miss_address, victim_way, memory_data, memory_data_valid,
    input  fsm_busy, mem_read_req, memory_address, data_out, data_write,
           word_enable, tag_write, fill_done
  );
`endif
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: reads an 8-word block from pipelined memory and writes it into the
// data array, then the tag array. Optional macro FILL_PERF_CNT_EN adds performance counters.
module cache_fill_fsm #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic              clk,
  input logic              rst,
  cache_fill_fsm_if.master bus
);

  localparam int CNT_W = $clog2(WORDS);
  localparam int OFS_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CNT_W:0]          r_req_cnt;
  logic [CNT_W-1:0]        r_rx_cnt;
  logic [ADDR_W-OFS_W-1:0] r_base;
  logic [1:0]              r_way;

  logic                    w_accept;
  logic                    w_req_active;
  logic                    w_rx_fire;
  logic                    w_last_rx;
  logic                    w_unused;

  logic                    w_busy;
  logic                    w_mem_read_req;
  logic [ADDR_W-1:0]       w_memory_address;
  logic [DATA_W-1:0]       w_data_out;
  logic [1:0]              w_data_write;
  logic [WORDS-1:0]        w_word_enable;
  logic [1:0]              w_tag_write;
  logic                    w_fill_done;

  function automatic logic [WORDS-1:0] onehot(input logic [CNT_W-1:0] idx);
    logic [WORDS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Byte offset within the block is dropped at latch time
  assign w_unused     = ^bus.miss_address[OFS_W-1:0];

  assign w_accept     = (r_state == S_IDLE) && bus.miss_detected;
  assign w_req_active = (r_state == S_FILL) && !r_req_cnt[CNT_W];
  assign w_rx_fire    = (r_state == S_FILL) && bus.memory_data_valid;
  assign w_last_rx    = w_rx_fire && (r_rx_cnt == CNT_W'(WORDS - 1));

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.miss_detected) w_next_state = S_FILL;
      S_FILL:  if (w_last_rx)         w_next_state = S_DONE;
      S_DONE:                         w_next_state = S_IDLE;
      default:                        w_next_state = S_IDLE;
    endcase
  end

  // ---- request / receive counters and latched miss context ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_cnt <= '0;
      r_rx_cnt  <= '0;
      r_base    <= '0;
      r_way     <= '0;
    end else if (w_accept) begin
      r_req_cnt <= '0;
      r_rx_cnt  <= '0;
      r_base    <= bus.miss_address[ADDR_W-1:OFS_W];
      r_way     <= bus.victim_way;
    end else begin
      // req_cnt parks at WORDS once every request is out
      if (w_req_active) r_req_cnt <= r_req_cnt + (CNT_W+1)'(1);
      if (w_rx_fire)    r_rx_cnt  <= r_rx_cnt + CNT_W'(1);
    end
  end

  // ---- output logic ----
  always_comb begin
    w_busy           = 1'b0;
    w_mem_read_req   = 1'b0;
    w_memory_address = '0;
    w_data_out       = '0;
    w_data_write     = '0;
    w_word_enable    = '0;
    w_tag_write      = '0;
    w_fill_done      = 1'b0;
    case (r_state)
      S_FILL: begin
        w_busy = 1'b1;
        if (w_req_active) begin
          w_mem_read_req   = 1'b1;
          w_memory_address = {r_base, r_req_cnt[CNT_W-1:0], 1'b0};
        end
        if (w_rx_fire) begin
          w_data_out    = bus.memory_data;
          w_data_write  = r_way;
          w_word_enable = onehot(r_rx_cnt);
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_tag_write = r_way;
        w_fill_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.fsm_busy       = w_busy;
  assign bus.mem_read_req   = w_mem_read_req;
  assign bus.memory_address = w_memory_address;
  assign bus.data_out       = w_data_out;
  assign bus.data_write     = w_data_write;
  assign bus.word_enable    = w_word_enable;
  assign bus.tag_write      = w_tag_write;
  assign bus.fill_done      = w_fill_done;

`ifdef FILL_PERF_CNT_EN
  logic [15:0] r_fill_count;
  logic [15:0] r_stall_cycles;

  // ---- performance counters, free-running with natural wrap ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_count   <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_fill_done) r_fill_count   <= r_fill_count + 16'd1;
      if (w_busy)      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign bus.fill_count   = r_fill_count;
  assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench for cache_fill_fsm: a queue-based memory model and a per-fill
// expectation model drive and check every cycle of each refill.
module tb_cache_fill_fsm;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WORDS  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_cycles = 0;
  int   fills = 0;

  cache_fill_fsm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) bus ();

  cache_fill_fsm #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"}, 32'(bus.fsm_busy), 0);
    check({tag, ".req"},  32'(bus.mem_read_req), 0);
    check({tag, ".addr"}, 32'(bus.memory_address), 0);
    check({tag, ".dout"}, 32'(bus.data_out), 0);
    check({tag, ".dw"},   32'(bus.data_write), 0);
    check({tag, ".we"},   32'(bus.word_enable), 0);
    check({tag, ".tw"},   32'(bus.tag_write), 0);
    check({tag, ".done"}, 32'(bus.fill_done), 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete refill, starting in an IDLE cycle. gap: 0 = return whenever ready,
  // 1 = alternate valid 1/0 with data 0xA000+i, 2 = random gaps.
  task automatic run_fill(input logic [15:0] addr, input logic [1:0] way, input int lat,
                          input int gap, input bit hold);
    int          pend[$];
    int          k;
    int          nrx;
    int          base;
    bit          tog;
    bit          v;
    logic [15:0] d;
    base = int'({addr[15:4], 4'h0});
    bus.miss_detected     = 1'b1;
    bus.miss_address      = addr;
    bus.victim_way        = way;
    bus.memory_data_valid = 1'($urandom_range(0, 1));
    bus.memory_data       = 16'($urandom);
    @(negedge clk);
    check_quiet("accept");
    next_cycle();
    k   = 0;
    nrx = 0;
    tog = 1'b1;
    while (nrx < WORDS && k < 200) begin
      if (k < WORDS) pend.push_back(k);
      v = 1'b0;
      if (pend.size() > 0 && pend[0] + lat <= k) begin
        case (gap)
          0:       v = 1'b1;
          1:       begin v = tog; tog = !tog; end
          default: v = 1'($urandom_range(0, 1));
        endcase
      end
      d = (gap == 1) ? 16'(16'hA000 + nrx) : 16'($urandom);
      if (v) void'(pend.pop_front());
      bus.memory_data_valid = v;
      bus.memory_data       = v ? d : 16'($urandom);
      bus.miss_detected     = hold;
      bus.miss_address      = 16'($urandom);
      bus.victim_way        = 2'($urandom);
      @(negedge clk);
      check("fill.busy", 32'(bus.fsm_busy), 1);
      check("fill.req",  32'(bus.mem_read_req), (k < WORDS) ? 1 : 0);
      check("fill.addr", 32'(bus.memory_address), (k < WORDS) ? base + 2 * k : 0);
      check("fill.we",   32'(bus.word_enable), v ? (1 << nrx) : 0);
      check("fill.dw",   32'(bus.data_write), v ? 32'(way) : 0);
      check("fill.dout", 32'(bus.data_out), v ? 32'(d) : 0);
      check("fill.tw",   32'(bus.tag_write), 0);
      check("fill.done", 32'(bus.fill_done), 0);
      busy_cycles++;
      if (v) nrx++;
      k++;
      next_cycle();
    end
    if (nrx < WORDS) check("fill.timeout", nrx, WORDS);
    // Completion cycle; a stray ninth word must be dropped
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'($urandom);
    bus.miss_detected     = hold;
    @(negedge clk);
    check("done.busy", 32'(bus.fsm_busy), 1);
    check("done.tw",   32'(bus.tag_write), 32'(way));
    check("done.done", 32'(bus.fill_done), 1);
    check("done.dw",   32'(bus.data_write), 0);
    check("done.we",   32'(bus.word_enable), 0);
    check("done.req",  32'(bus.mem_read_req), 0);
    busy_cycles++;
    fills++;
    next_cycle();
  endtask

  // Refill aborted by an asynchronous reset after three words have landed
  task automatic reset_mid_fill();
    bus.miss_detected     = 1'b1;
    bus.miss_address      = 16'h4A5C;
    bus.victim_way        = 2'b10;
    bus.memory_data_valid = 1'b0;
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      bus.miss_detected     = 1'b0;
      bus.memory_data_valid = (k >= 1);
      bus.memory_data       = 16'(16'h5000 + k);
      @(negedge clk);
      check("rmf.addr", 32'(bus.memory_address), 32'h4A50 + 2 * k);
      check("rmf.we",   32'(bus.word_enable), (k >= 1) ? (1 << (k - 1)) : 0);
      busy_cycles++;
      next_cycle();
    end
    bus.memory_data_valid = 1'b1;
    @(negedge clk);
    check("rmf.we3", 32'(bus.word_enable), 32'h08);
    #2 rst = 1'b1;
    busy_cycles = 0;
    fills       = 0;
    #1;
    check_quiet("rst_async");
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = 16'($urandom);
      @(negedge clk);
      check_quiet("post_rst");
      next_cycle();
    end
  endtask

  initial begin
    logic [1:0] way;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = '0;
    bus.victim_way        = '0;
    bus.memory_data       = '0;
    bus.memory_data_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle");
    next_cycle();

    reset_mid_fill();
    run_fill(16'h1236, 2'b01, 4, 0, 1'b0);
    run_fill(16'hFFFF, 2'b10, 4, 0, 1'b0);
    run_fill(16'($urandom), 2'b01, 4, 1, 1'b0);
    run_fill(16'h2460, 2'b10, 3, 2, 1'b1);
    run_fill(16'h8ACE, 2'b01, 4, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      way = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      run_fill(16'($urandom), way, int'($urandom_range(1, 6)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)));
    end

    bus.miss_detected     = 1'b0;
    bus.memory_data_valid = 1'b1;
    @(negedge clk);
    check_quiet("final");
`ifdef FILL_PERF_CNT_EN
    check("perf.fill_count",   32'(bus.fill_count), fills);
    check("perf.stall_cycles", 32'(bus.stall_cycles), busy_cycles);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
